// File: rtl/timer_arbiter_bdeduffy.sv
// Two-requester round-robin arbiter for a single shared interval counter.
// Each grant latches a terminal count, runs count 0..tc (pausable, abortable) and pulses done.
module timer_arbiter_bdeduffy #(
    parameter int CNTW = 9
) (
    input  logic            clk_i,
    input  logic            clear_n_i,
    input  logic [1:0]      req_i,
    input  logic [CNTW-1:0] len0_i,
    input  logic [CNTW-1:0] len1_i,
    input  logic            hold_i,
    input  logic            abort_i,
    output logic [1:0]      gnt_o,
    output logic            busy_o,
    output logic [1:0]      done_o,
    output logic [CNTW-1:0] count_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

    state_e          state_q;
    logic [1:0]      gnt_q;
    logic [1:0]      done_q;
    logic            busy_q;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] tc_q;
    logic            winner_q;
    logic            last_q;

    logic            winner_d;
    logic [CNTW-1:0] tc_d;

    // On a tie the requester that was not served last wins; otherwise the lone requester wins.
    always_comb begin
        winner_d = req_i[1];
        if (req_i == 2'b11) begin
            winner_d = ~last_q;
        end
        tc_d = winner_d ? len1_i : len0_i;
    end

    always_ff @(posedge clk_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            busy_q   <= 1'b0;
            count_q  <= '0;
            tc_q     <= '0;
            winner_q <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            done_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (req_i != 2'b00) begin
                        state_q  <= LOAD;
                        winner_q <= winner_d;
                        gnt_q    <= winner_d ? 2'b10 : 2'b01;
                        busy_q   <= 1'b1;
                        tc_q     <= tc_d;
                        count_q  <= '0;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        last_q  <= winner_q;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Abort outranks hold and the terminal compare; the compare precedes the increment so count never wraps.
                    if (abort_i) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        last_q  <= winner_q;
                    end else if (!hold_i) begin
                        if (count_q == tc_q) begin
                            state_q <= DONE;
                            done_q  <= gnt_q;
                            last_q  <= winner_q;
                        end else begin
                            count_q <= count_q + CntOne;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_timer_arbiter_bdeduffy.sv
// Directed bench for timer_arbiter_bdeduffy: an interval-age model is checked every cycle,
// with literal expectations at the key points of each scenario.
module tb_timer_arbiter_bdeduffy;

    localparam int CNTW = 9;

    logic            clk;
    logic            clearN;
    logic [1:0]      req;
    logic [CNTW-1:0] len0;
    logic [CNTW-1:0] len1;
    logic            hold;
    logic            abort;
    logic [1:0]      gnt;
    logic            busy;
    logic [1:0]      done;
    logic [CNTW-1:0] count;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Model: an interval is described by its winner, its terminal count and its age.
    // Age 0 is the grant cycle, ages 1..tc+1 are counting cycles (count = age-1), age tc+2 is completion.
    bit mActive;
    int mWinner;
    int mAge;
    int mTc;
    int mLast;
    int mHeldCount;

    int grantSeen[$];
    int doneSeen;
    logic [1:0] prevGnt;
    int expectedOrder[4] = '{1, 2, 1, 2};

    timer_arbiter_bdeduffy #(.CNTW(CNTW)) dut (
        .clk_i    (clk),
        .clear_n_i(clearN),
        .req_i    (req),
        .len0_i   (len0),
        .len1_i   (len1),
        .hold_i   (hold),
        .abort_i  (abort),
        .gnt_o    (gnt),
        .busy_o   (busy),
        .done_o   (done),
        .count_o  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
        end
    endtask

    task automatic modelReset();
        mActive    = 1'b0;
        mWinner    = 0;
        mAge       = 0;
        mTc        = 0;
        mLast      = 1;
        mHeldCount = 0;
    endtask

    function automatic int expCount();
        if (!mActive) return mHeldCount;
        if (mAge == 0) return 0;
        if (mAge <= mTc + 1) return mAge - 1;
        return mTc;
    endfunction

    function automatic int expGnt();
        return mActive ? (1 << mWinner) : 0;
    endfunction

    task automatic modelStep();
        if (!clearN) begin
            modelReset();
        end else if (!mActive) begin
            if (req != 2'b00) begin
                if (req == 2'b11) mWinner = 1 - mLast;
                else mWinner = (req == 2'b10) ? 1 : 0;
                mTc        = (mWinner == 1) ? int'(len1) : int'(len0);
                mActive    = 1'b1;
                mAge       = 0;
                mHeldCount = 0;
            end
        end else if (mAge <= mTc + 1) begin
            if (abort) begin
                mHeldCount = expCount();
                mActive    = 1'b0;
                mLast      = mWinner;
            end else if (mAge == 0) begin
                mAge = 1;
            end else if (!hold) begin
                if (mAge == mTc + 1) mLast = mWinner;
                mAge++;
            end
        end else begin
            mHeldCount = mTc;
            mActive    = 1'b0;
        end
    endtask

    task automatic checkOutput();
        check("gnt", int'(gnt), expGnt());
        check("busy", int'(busy), int'(mActive));
        check("done", int'(done), (mActive && mAge == mTc + 2) ? expGnt() : 0);
        check("count", int'(count), expCount());
    endtask

    task automatic tick();
        @(posedge clk);
        cycle++;
        modelStep();
        #2;
        checkOutput();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input int r, input int l0, input int l1, input int h, input int a);
        req   = 2'(r);
        len0  = CNTW'(l0);
        len1  = CNTW'(l1);
        hold  = 1'(h);
        abort = 1'(a);
    endtask

    task automatic syncReset();
        clearN = 1'b0;
        tick();
        clearN = 1'b1;
        tick();
    endtask

    initial begin
        modelReset();
        clearN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        runCycles(2);
        check("reset gnt", int'(gnt), 0);
        check("reset count", int'(count), 0);
        clearN = 1'b1;
        tick();

        // Single request, len0=3: count 0..3, done in the sixth cycle after the request edge.
        applyStimulus(1, 3, 0, 0, 0);
        tick();
        check("A gnt at load", int'(gnt), 1);
        applyStimulus(0, 3, 0, 0, 0);
        runCycles(4);
        check("A count before done", int'(count), 3);
        check("A no early done", int'(done), 0);
        tick();
        check("A done pulse", int'(done), 1);
        check("A gnt in done", int'(gnt), 1);
        tick();
        check("A busy low", int'(busy), 0);
        check("A count holds", int'(count), 3);

        // Tie after reset: grants alternate starting with requester 0.
        syncReset();
        applyStimulus(3, 1, 1, 0, 0);
        doneSeen = 0;
        prevGnt  = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt != 2'b00 && prevGnt == 2'b00) grantSeen.push_back(int'(gnt));
            if (done != 2'b00) doneSeen++;
            prevGnt = gnt;
        end
        applyStimulus(0, 1, 1, 0, 0);
        check("B grant count", grantSeen.size(), 4);
        for (int i = 0; i < grantSeen.size() && i < 4; i++) begin
            check("B grant order", grantSeen[i], expectedOrder[i]);
        end
        check("B done pulses", doneSeen, 4);
        tick();

        // len0=0: exactly one counting cycle.
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        check("C no done in run", int'(done), 0);
        tick();
        check("C done at k+3", int'(done), 1);
        check("C count zero", int'(count), 0);
        tick();

        // len1=511: full-range count without wrap; len change after grant is ignored.
        applyStimulus(2, 0, 511, 0, 0);
        tick();
        check("D gnt at load", int'(gnt), 2);
        applyStimulus(0, 0, 5, 0, 0);
        runCycles(512);
        check("D count max", int'(count), 511);
        check("D no early done", int'(done), 0);
        tick();
        check("D done at k+514", int'(done), 2);
        check("D count in done", int'(count), 511);
        tick();
        check("D count no wrap", int'(count), 511);
        check("D gnt cleared", int'(gnt), 0);

        // Hold for four cycles mid-count delays done by four cycles.
        applyStimulus(1, 6, 0, 0, 0);
        tick();
        applyStimulus(0, 6, 0, 0, 0);
        runCycles(3);
        check("E count before hold", int'(count), 2);
        applyStimulus(0, 6, 0, 1, 0);
        runCycles(4);
        check("E count frozen", int'(count), 2);
        applyStimulus(0, 6, 0, 0, 0);
        runCycles(4);
        check("E no done yet", int'(done), 0);
        tick();
        check("E delayed done", int'(done), 1);
        tick();

        // Abort at count 5 (together with hold), then pointer advancement on abort.
        applyStimulus(2, 0, 20, 0, 0);
        tick();
        applyStimulus(0, 0, 20, 0, 0);
        runCycles(6);
        check("F count before abort", int'(count), 5);
        applyStimulus(0, 0, 20, 1, 1);
        tick();
        check("F abort gnt", int'(gnt), 0);
        check("F abort busy", int'(busy), 0);
        check("F abort no done", int'(done), 0);
        check("F abort count held", int'(count), 5);
        applyStimulus(3, 2, 2, 0, 0);
        tick();
        check("F pointer advanced", int'(gnt), 1);
        applyStimulus(0, 2, 2, 0, 1);
        tick();
        check("F abort in load", int'(gnt), 0);
        applyStimulus(3, 2, 2, 0, 0);
        tick();
        check("F pointer after load abort", int'(gnt), 2);
        applyStimulus(0, 2, 2, 0, 0);
        runCycles(4);
        check("F done after tie", int'(done), 2);
        applyStimulus(0, 2, 2, 0, 1);
        runCycles(2);
        applyStimulus(0, 2, 2, 0, 0);

        // Asynchronous reset between edges abandons the interval.
        applyStimulus(1, 10, 0, 0, 0);
        tick();
        applyStimulus(0, 10, 0, 0, 0);
        runCycles(3);
        check("G count before reset", int'(count), 2);
        #1;
        clearN = 1'b0;
        modelReset();
        #1;
        check("G async gnt", int'(gnt), 0);
        check("G async busy", int'(busy), 0);
        check("G async done", int'(done), 0);
        check("G async count", int'(count), 0);
        clearN = 1'b1;
        applyStimulus(3, 4, 4, 0, 0);
        tick();
        check("G tie after reset", int'(gnt), 1);
        applyStimulus(0, 4, 4, 0, 0);
        runCycles(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
